// File: rtl/flash_playback_controller.sv
// Flash audio playback sequencer: flash word address plus sample-rate strobe.
// Define AUDIO_LOOP_EN to wrap at the track ends instead of pausing there.
module flash_playback_controller #(
   parameter int unsigned           ADDR_W      = 23,
   parameter logic [ADDR_W-1:0]     ADDR_MAX    = 23'h7FFFF,
   parameter int unsigned           DIV_W       = 16,
   parameter logic [DIV_W-1:0]      DIV_DEFAULT = 16'd1136,
   parameter logic [DIV_W-1:0]      DIV_STEP    = 16'd64,
   parameter logic [DIV_W-1:0]      DIV_MIN     = 16'd256,
   parameter logic [DIV_W-1:0]      DIV_MAX     = 16'd4096
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_play,
   input  logic              cmd_pause,
   input  logic              cmd_fwd,
   input  logic              cmd_bwd,
   input  logic              cmd_restart,
   input  logic              cmd_faster,
   input  logic              cmd_slower,
   input  logic              rd_inc,
   input  logic              rd_reset,
   output logic              samplenow,
   output logic [ADDR_W-1:0] address,
   output logic              playing,
   output logic              dir_bwd,
   output logic [DIV_W-1:0]  divider
);

   typedef enum logic {
      S_PAUSED = 1'b0,
      S_PLAY   = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] A_ZERO = '0;
   localparam logic [DIV_W-1:0]  D_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

   state_t             r_state;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_dir;
   logic [DIV_W-1:0]   r_div;
   logic [DIV_W-1:0]   r_tick;
   logic               r_sample;

   logic               w_restart;
   logic               w_at_end;
   logic               w_stop;
   logic [ADDR_W-1:0]  w_addr_step;
   logic [DIV_W:0]     w_dec_raw;
   logic [DIV_W:0]     w_inc_raw;
   logic [DIV_W-1:0]   w_div_dn;
   logic [DIV_W-1:0]   w_div_up;
   logic [DIV_W-1:0]   w_div_m1;

   assign w_restart = cmd_restart | rd_reset;
   assign w_at_end  = r_dir ? (r_addr == A_ZERO) : (r_addr == ADDR_MAX);

`ifdef AUDIO_LOOP_EN
   assign w_stop = 1'b0;
   always_comb begin
      w_addr_step = r_dir ? (r_addr - A_ONE) : (r_addr + A_ONE);
      if (w_at_end)
         w_addr_step = r_dir ? ADDR_MAX : A_ZERO;
   end
`else
   assign w_stop = rd_inc & ~w_restart & w_at_end;
   always_comb begin
      w_addr_step = r_dir ? (r_addr - A_ONE) : (r_addr + A_ONE);
      if (w_at_end)
         w_addr_step = r_addr;
   end
`endif

   // Widened by one bit so a borrow or carry is visible before saturating.
   assign w_dec_raw = {1'b0, r_div} - {1'b0, DIV_STEP};
   assign w_inc_raw = {1'b0, r_div} + {1'b0, DIV_STEP};
   assign w_div_dn  = (w_dec_raw[DIV_W] || (w_dec_raw[DIV_W-1:0] < DIV_MIN))
                      ? DIV_MIN : w_dec_raw[DIV_W-1:0];
   assign w_div_up  = (w_inc_raw > {1'b0, DIV_MAX})
                      ? DIV_MAX : w_inc_raw[DIV_W-1:0];
   assign w_div_m1  = r_div - D_ONE;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_PAUSED;
         r_addr   <= '0;
         r_dir    <= 1'b0;
         r_div    <= DIV_DEFAULT;
         r_tick   <= '0;
         r_sample <= 1'b0;
      end else begin
         if (cmd_pause || w_stop)
            r_state <= S_PAUSED;
         else if (cmd_play)
            r_state <= S_PLAY;

         if (cmd_fwd && !cmd_bwd)
            r_dir <= 1'b0;
         else if (cmd_bwd && !cmd_fwd)
            r_dir <= 1'b1;

         if (cmd_faster && !cmd_slower)
            r_div <= w_div_dn;
         else if (cmd_slower && !cmd_faster)
            r_div <= w_div_up;

         if (w_restart)
            r_addr <= r_dir ? ADDR_MAX : A_ZERO;
         else if (rd_inc)
            r_addr <= w_addr_step;

         // >= lets a freshly shrunk divider fire at once rather than wrap.
         if (w_restart || r_state != S_PLAY) begin
            r_tick   <= '0;
            r_sample <= 1'b0;
         end else if (r_tick >= w_div_m1) begin
            r_tick   <= '0;
            r_sample <= 1'b1;
         end else begin
            r_tick   <= r_tick + D_ONE;
            r_sample <= 1'b0;
         end
      end
   end

   assign samplenow = r_sample;
   assign address   = r_addr;
   assign playing   = (r_state == S_PLAY);
   assign dir_bwd   = r_dir;
   assign divider   = r_div;

endmodule

// File: doc/flash_playback_controller.md
Name: flash_playback_controller

Overview:
- Sequences flash audio playback: owns the flash word address and generates the sample-rate `samplenow` strobe consumed by the flash reader.
- Applies the reader's per-word advance and restart strobes in the current playback direction.
- Takes single-cycle user commands from the keyboard decoder: play, pause, direction, restart, speed.
- Sits between the keyboard decoder, the flash reader and the flash address bus.

Parameters:
- ADDR_W, 23: flash word-address width.
- ADDR_MAX, 23'h7FFFF: last valid word address (inclusive).
- DIV_W, 16: sample divider width.
- DIV_DEFAULT, 16'd1136: clk cycles per sample after reset (50 MHz / 44 kHz).
- DIV_STEP, 16'd64: divider change per faster/slower command.
- DIV_MIN, 16'd256: minimum divider (fastest).
- DIV_MAX, 16'd4096: maximum divider (slowest).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_play  in  1  pulse: enter PLAY.
- cmd_pause  in  1  pulse: enter PAUSED.
- cmd_fwd  in  1  pulse: direction := forward.
- cmd_bwd  in  1  pulse: direction := backward.
- cmd_restart  in  1  pulse: jump to start of track for the current direction.
- cmd_faster  in  1  pulse: divider -= DIV_STEP.
- cmd_slower  in  1  pulse: divider += DIV_STEP.
- rd_inc  in  1  pulse from reader: word consumed, advance address.
- rd_reset  in  1  pulse from reader: same effect as cmd_restart.
- samplenow  out  1  one-cycle sample strobe to reader.
- address  out  ADDR_W  current flash word address.
- playing  out  1  1 in PLAY state.
- dir_bwd  out  1  1 = backward.
- divider  out  DIV_W  current divider value.

Behaviour:
- **Reset values** (asynchronous on reset_n low): state PAUSED, address 0, dir_bwd 0, divider DIV_DEFAULT, tick counter 0, samplenow 0.
- **Two-state FSM:**
  - PAUSED -> PLAY on cmd_play.
  - PLAY -> PAUSED on cmd_pause.
  - cmd_pause and cmd_play in the same cycle: pause wins.
- **Direction register:**
  - cmd_fwd clears dir_bwd; cmd_bwd sets it.
  - Both in the same cycle: no change.
  - Direction changes are allowed in either state and take effect on the next rd_inc.
- **Tick counter:**
  - Counts only in PLAY; held at 0 in PAUSED.
  - When tick >= divider-1: samplenow=1 for exactly that cycle and tick := 0; otherwise tick += 1.
  - The >= compare ensures a divider reduced below the current tick fires on the next cycle, with no wrap through 2^DIV_W.
  - samplenow is registered: first strobe after entering PLAY occurs `divider` cycles after the cmd_play edge.
- **Speed commands:**
  - cmd_faster: divider := max(divider-DIV_STEP, DIV_MIN).
  - cmd_slower: divider := min(divider+DIV_STEP, DIV_MAX).
  - Both in the same cycle: no change.
  - Arithmetic is done at DIV_W+1 bits, then saturated.
- **Address update** (priority high to low):
  1. Restart (cmd_restart or rd_reset): address := 0 if forward, ADDR_MAX if backward; tick := 0.
  2. rd_inc: address ± 1 per direction, with boundary handling (see Optional Feature).
  3. Otherwise hold.
  - rd_inc is honoured in both states, so an in-flight reader word completes after pause.
- **Simultaneous events:** restart together with rd_inc gives the restart address; the step is dropped.
- **Reset mid-operation:** all state returns to reset values immediately; the reader must tolerate samplenow dropping.

Optional Feature:
- Macro: AUDIO_LOOP_EN.
- Defined:
  - Forward at ADDR_MAX + rd_inc -> address 0.
  - Backward at 0 + rd_inc -> ADDR_MAX.
  - Play continues.
- Undefined:
  - At either end, rd_inc holds the address at the bound and forces state to PAUSED the next cycle; playing drops.
  - cmd_restart or cmd_play re-arms playback.

Test Plan:
- Reset with DIV_DEFAULT=4; hold PAUSED 20 cycles -> samplenow never asserts, address=0, divider=4. Then cmd_play -> samplenow pulses on cycles 4, 8, 12 after play, each pulse 1 cycle wide.
- Forward, address=5, three rd_inc pulses -> address=8. Then cmd_bwd + two rd_inc -> address=6.
- Wrap with ADDR_MAX=15, address=15, forward rd_inc:
  - with AUDIO_LOOP_EN -> address=0, playing=1;
  - without -> address=15, playing=0 next cycle.
- Backward at address 0 + rd_inc:
  - with loop -> address=15;
  - without -> address=0, PAUSED.
- Speed with DIV_MIN=256, DIV_STEP=64, divider=300:
  - cmd_faster -> 256;
  - cmd_faster again -> 256;
  - 60 cmd_slower -> saturates at 4096.
  - Shrink divider while tick=1000 -> samplenow next cycle.
- Simultaneous events:
  - backward + cmd_restart and rd_inc same cycle -> address=ADDR_MAX;
  - cmd_play and cmd_pause same cycle -> stays PAUSED.
- reset_n low mid-PLAY between clock edges -> outputs to reset values immediately.
